// File: rtl/mt32_pkg.sv
// mt32_pkg -- shared definitions for the MT19937 controller slice.
//
// Contents:
//   N         : words in the MT19937 state array (624)
//   AW        : state-RAM address width, derived from N (10)
//   DW        : word width (32)
//   DEF_SEED  : seed loaded by the optional autoseed after reset (5489)
//   state_e   : controller state encoding (IDLE, INIT, RUN, HOLD)
//   sat_inc   : saturating 32-bit increment used by the accepted-word counter

package mt32_pkg;

  localparam int unsigned N  = 624;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned DW = 32;

  localparam logic [31:0] DEF_SEED = 32'd5489;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Counter sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mt32_ram_arb.sv
// mt32_ram_arb -- state-RAM write-port multiplexer.
//
// Selects which unit owns the single state-RAM write port, purely from the
// controller's state register (no extra pipeline stage):
//   INIT      : init unit port   (init_waddr / init_wen / init_wdata)
//   RUN       : engine port      (gen_waddr  / gen_wen  / gen_wdata)
//   IDLE/HOLD : port parked, all fields driven to 0
//
// Ports:
//   state                         : controller state register (state_e encoding)
//   init_waddr/init_wen/init_wdata: init unit write request
//   gen_waddr/gen_wen/gen_wdata   : engine write request
//   ram_waddr/ram_wen/ram_wdata   : arbitrated write port to the state RAM

module mt32_ram_arb
  import mt32_pkg::*;
(
  input  logic [1:0]    state,
  input  logic [AW-1:0] init_waddr,
  input  logic          init_wen,
  input  logic [DW-1:0] init_wdata,
  input  logic [AW-1:0] gen_waddr,
  input  logic          gen_wen,
  input  logic [DW-1:0] gen_wdata,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_wen,
  output logic [DW-1:0] ram_wdata
);

  state_e st;
  assign st = state_e'(state);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // a value unassigned -- otherwise synthesis infers a latch.
    ram_waddr = '0;
    ram_wen   = 1'b0;
    ram_wdata = '0;
    case (st)
      ST_INIT: begin
        ram_waddr = init_waddr;
        ram_wen   = init_wen;
        ram_wdata = init_wdata;
      end
      ST_RUN: begin
        ram_waddr = gen_waddr;
        ram_wen   = gen_wen;
        ram_wdata = gen_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mt32_ctrl.sv
// mt32_ctrl -- sequencing controller for an MT19937 generator.
//
// Owns the IDLE / INIT / RUN / HOLD state machine that reseeds the state RAM
// through an external init unit, then lets the twist/temper engine run and
// hands tempered words to a ready/valid consumer.
//
// Build option: define MT32_CTRL_AUTOSEED_EN to start an init with DEF_SEED
// in the first cycle after reset release; otherwise the controller waits in
// IDLE for seed_req.
//
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   seed_req, seed_in  : reseed request and seed value
//   pause, resume      : stop / restart number production
//   init_go, init_seed : one-cycle start pulse and latched seed to init unit
//   init_waddr/wen/wdata, init_done : init unit RAM writes and completion pulse
//   gen_en             : engine enable
//   gen_waddr/wen/wdata, gen_valid, gen_rnd : engine RAM writes and output word
//   ram_waddr/wen/wdata: arbitrated state-RAM write port
//   rnd_valid, rnd, rnd_ready : consumer handshake
//   busy               : high while initialising
//   word_cnt           : words accepted since the last seed (saturating)
//
// The state RAM itself lives outside this block and is never cleared by
// reset; after a reset during INIT its contents stay undefined until the next
// init completes.

module mt32_ctrl
  import mt32_pkg::*;
#(
  parameter logic [31:0] DEF_SEED = mt32_pkg::DEF_SEED
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          seed_req,
  input  logic [31:0]   seed_in,
  input  logic          pause,
  input  logic          resume,
  output logic          init_go,
  output logic [31:0]   init_seed,
  input  logic [9:0]    init_waddr,
  input  logic          init_wen,
  input  logic [31:0]   init_wdata,
  input  logic          init_done,
  output logic          gen_en,
  input  logic [9:0]    gen_waddr,
  input  logic          gen_wen,
  input  logic [31:0]   gen_wdata,
  input  logic          gen_valid,
  input  logic [31:0]   gen_rnd,
  output logic [9:0]    ram_waddr,
  output logic          ram_wen,
  output logic [31:0]   ram_wdata,
  output logic          rnd_valid,
  output logic [31:0]   rnd,
  input  logic          rnd_ready,
  output logic          busy,
  output logic [31:0]   word_cnt
);

`ifdef MT32_CTRL_AUTOSEED_EN
  localparam logic AUTOSEED = 1'b1;
`else
  localparam logic AUTOSEED = 1'b0;
`endif

  state_e      state_q,     state_d;
  logic        init_go_q,   init_go_d;
  logic [31:0] init_seed_q, init_seed_d;
  logic        pending_q,   pending_d;
  logic [31:0] word_cnt_q,  word_cnt_d;
  // Set by reset, cleared after the first clock: marks the autoseed cycle.
  logic        first_q,     first_d;

  logic        in_run;
  logic        accept;
  logic        seed_evt;
  logic [31:0] seed_val;

  assign in_run    = (state_q == ST_RUN);
  assign accept    = gen_valid & in_run & rnd_ready;

  // A user seed_req overrides the autoseed value if both land together.
  assign seed_evt  = seed_req | (AUTOSEED & first_q);
  assign seed_val  = seed_req ? seed_in : DEF_SEED;

  always_comb begin
    state_d     = state_q;
    init_go_d   = 1'b0;
    init_seed_d = init_seed_q;
    pending_d   = pending_q;
    word_cnt_d  = word_cnt_q;
    first_d     = 1'b0;

    if (accept) begin
      word_cnt_d = sat_inc(word_cnt_q);
    end

    case (state_q)
      ST_INIT: begin
        // A reseed during INIT cannot interrupt the running init unit, so it
        // is parked as pending and replayed when the current pass finishes.
        if (seed_req) begin
          init_seed_d = seed_in;
          pending_d   = 1'b1;
        end
        if (init_done) begin
          if (pending_q || seed_req) begin
            init_go_d  = 1'b1;
            pending_d  = 1'b0;
            word_cnt_d = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        // IDLE, RUN, HOLD: seed_req outranks pause and resume.
        if (seed_evt) begin
          init_seed_d = seed_val;
          word_cnt_d  = '0;
          init_go_d   = 1'b1;
          pending_d   = 1'b0;
          state_d     = ST_INIT;
        end else if (state_q == ST_RUN && pause) begin
          state_d = ST_HOLD;
        end else if (state_q == ST_HOLD && resume && !pause) begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      init_go_q   <= 1'b0;
      init_seed_q <= '0;
      pending_q   <= 1'b0;
      word_cnt_q  <= '0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_go_q   <= init_go_d;
      init_seed_q <= init_seed_d;
      pending_q   <= pending_d;
      word_cnt_q  <= word_cnt_d;
      first_q     <= first_d;
    end
  end

  assign init_go   = init_go_q;
  assign init_seed = init_seed_q;
  assign word_cnt  = word_cnt_q;
  assign busy      = (state_q == ST_INIT);
  assign rnd_valid = gen_valid & in_run;
  assign rnd       = gen_rnd;
  // Engine advances only when its current word will be taken (or it has none).
  assign gen_en    = in_run & (rnd_ready | ~gen_valid);

  mt32_ram_arb u_ram_arb (
    .state      (state_q),
    .init_waddr (init_waddr),
    .init_wen   (init_wen),
    .init_wdata (init_wdata),
    .gen_waddr  (gen_waddr),
    .gen_wen    (gen_wen),
    .gen_wdata  (gen_wdata),
    .ram_waddr  (ram_waddr),
    .ram_wen    (ram_wen),
    .ram_wdata  (ram_wdata)
  );

endmodule

// File: tb/tb_mt32_ctrl.sv
// tb_mt32_ctrl -- self-checking bench for mt32_ctrl.
// Table of scripted vectors, hand sequences for init/pending/reset corners,
// then randomized stimulus against a behavioural model of the controller.

module tb_mt32_ctrl;

`ifdef MT32_CTRL_AUTOSEED_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_req;
  logic [31:0] seed_in;
  logic        pause, resume;
  logic        init_go;
  logic [31:0] init_seed;
  logic [9:0]  init_waddr;
  logic        init_wen;
  logic [31:0] init_wdata;
  logic        init_done;
  logic        gen_en;
  logic [9:0]  gen_waddr;
  logic        gen_wen;
  logic [31:0] gen_wdata;
  logic        gen_valid;
  logic [31:0] gen_rnd;
  logic [9:0]  ram_waddr;
  logic        ram_wen;
  logic [31:0] ram_wdata;
  logic        rnd_valid;
  logic [31:0] rnd;
  logic        rnd_ready;
  logic        busy;
  logic [31:0] word_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  mt32_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .seed_req   (seed_req),
    .seed_in    (seed_in),
    .pause      (pause),
    .resume     (resume),
    .init_go    (init_go),
    .init_seed  (init_seed),
    .init_waddr (init_waddr),
    .init_wen   (init_wen),
    .init_wdata (init_wdata),
    .init_done  (init_done),
    .gen_en     (gen_en),
    .gen_waddr  (gen_waddr),
    .gen_wen    (gen_wen),
    .gen_wdata  (gen_wdata),
    .gen_valid  (gen_valid),
    .gen_rnd    (gen_rnd),
    .ram_waddr  (ram_waddr),
    .ram_wen    (ram_wen),
    .ram_wdata  (ram_wdata),
    .rnd_valid  (rnd_valid),
    .rnd        (rnd),
    .rnd_ready  (rnd_ready),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    seed_req = 0; seed_in = 0; pause = 0; resume = 0;
    init_waddr = 0; init_wen = 0; init_wdata = 0; init_done = 0;
    gen_waddr = 0; gen_wen = 0; gen_wdata = 0; gen_valid = 0; gen_rnd = 0;
    rnd_ready = 0;
  endtask

  function automatic logic [63:0] all_outs();
    return {32'(busy) ^ 32'(init_go) ^ 32'(gen_en) ^ 32'(ram_wen) ^ 32'(rnd_valid),
            init_seed | word_cnt | ram_wdata | rnd | 32'(ram_waddr)};
  endfunction

  task automatic reset_dut();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", all_outs(), 64'd0);
    reset = 1'b0;
  endtask

  // First cycle after release: autoseed build starts an init, default stays idle.
  // Either way the DUT is left in RUN or IDLE with word_cnt 0.
  task automatic after_reset();
    tick();
`ifdef MT32_CTRL_AUTOSEED_EN
    check("autoseed", {30'd0, init_go, busy, init_seed}, {30'd0, 1'b1, 1'b1, 32'd5489});
    init_done = 1; tick(); init_done = 0;
    check("autoseed_run", {63'd0, busy}, 64'd0);
`else
    check("idle_after_reset", {30'd0, init_go, busy, init_seed}, 64'd0);
`endif
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    string       name;
    logic        seed_req;
    logic [31:0] seed_in;
    logic        pause, resume, init_done;
    logic        init_wen;
    logic [9:0]  init_waddr;
    logic [31:0] init_wdata;
    logic        gen_wen;
    logic [9:0]  gen_waddr;
    logic [31:0] gen_wdata;
    logic        gen_valid, rnd_ready;
    logic [31:0] gen_rnd;
    logic        e_busy, e_go, e_rv, e_ge, e_rw;
    logic [31:0] e_seed, e_cnt;
    logic [9:0]  e_ra;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t vz(input string name);
    vec_t v;
    v = '{name: name, default: '0};
    return v;
  endfunction

  vec_t tv[$];

  task automatic build_table();
    vec_t v;
    v = vz("seed_idle"); v.seed_req = 1; v.seed_in = 32'd5489;
    v.e_busy = 1; v.e_go = 1; v.e_seed = 32'd5489; tv.push_back(v);
    v = vz("init_mux"); v.init_wen = 1; v.init_waddr = 10'h3FF; v.init_wdata = 32'hA5A5_0001;
    v.gen_wen = 1; v.gen_waddr = 10'h011; v.gen_wdata = 32'h0000_0BAD;
    v.e_busy = 1; v.e_rw = 1; v.e_ra = 10'h3FF; v.e_rd = 32'hA5A5_0001; v.e_seed = 32'd5489; tv.push_back(v);
    v = vz("init_done_run"); v.init_done = 1; v.e_ge = 1; v.e_seed = 32'd5489; tv.push_back(v);
    v = vz("run_mux_acc1"); v.gen_valid = 1; v.rnd_ready = 1; v.gen_rnd = 32'h1111_0001;
    v.gen_wen = 1; v.gen_waddr = 10'd7; v.gen_wdata = 32'hC0DE_0007;
    v.init_wen = 1; v.init_waddr = 10'd1; v.init_wdata = 32'h0000_0BAD;
    v.e_rv = 1; v.e_ge = 1; v.e_rw = 1; v.e_ra = 10'd7; v.e_rd = 32'hC0DE_0007;
    v.e_seed = 32'd5489; v.e_cnt = 1; tv.push_back(v);
    v = vz("acc2"); v.gen_valid = 1; v.rnd_ready = 1; v.gen_rnd = 32'h2222_0002;
    v.e_rv = 1; v.e_ge = 1; v.e_seed = 32'd5489; v.e_cnt = 2; tv.push_back(v);
    v = vz("not_ready"); v.gen_valid = 1; v.gen_rnd = 32'h3333_0003;
    v.e_rv = 1; v.e_seed = 32'd5489; v.e_cnt = 2; tv.push_back(v);
    v = vz("pause_hold"); v.pause = 1; v.gen_valid = 1; v.rnd_ready = 1; v.gen_rnd = 32'h4444_0004;
    v.gen_wen = 1; v.gen_waddr = 10'd9; v.gen_wdata = 32'h99;
    v.e_seed = 32'd5489; v.e_cnt = 3; tv.push_back(v);
    v = vz("pause_resume_hold"); v.pause = 1; v.resume = 1; v.gen_valid = 1; v.rnd_ready = 1;
    v.gen_rnd = 32'h5555_0005; v.e_seed = 32'd5489; v.e_cnt = 3; tv.push_back(v);
    v = vz("resume_run"); v.resume = 1; v.gen_valid = 1; v.rnd_ready = 1; v.gen_rnd = 32'h6666_0006;
    v.e_rv = 1; v.e_ge = 1; v.e_seed = 32'd5489; v.e_cnt = 3; tv.push_back(v);
    v = vz("acc4"); v.gen_valid = 1; v.rnd_ready = 1; v.gen_rnd = 32'h7777_0007;
    v.e_rv = 1; v.e_ge = 1; v.e_seed = 32'd5489; v.e_cnt = 4; tv.push_back(v);
    v = vz("stray_done"); v.init_done = 1; v.e_ge = 1; v.e_seed = 32'd5489; v.e_cnt = 4; tv.push_back(v);
    v = vz("reseed_run"); v.seed_req = 1; v.seed_in = 32'hDEAD_BEEF; v.gen_valid = 1; v.rnd_ready = 1;
    v.gen_rnd = 32'h8888_0008; v.e_busy = 1; v.e_go = 1; v.e_seed = 32'hDEAD_BEEF; tv.push_back(v);
    v = vz("go_one_cycle"); v.e_busy = 1; v.e_seed = 32'hDEAD_BEEF; tv.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v);
    seed_req = v.seed_req; seed_in = v.seed_in; pause = v.pause; resume = v.resume;
    init_done = v.init_done; init_wen = v.init_wen; init_waddr = v.init_waddr; init_wdata = v.init_wdata;
    gen_wen = v.gen_wen; gen_waddr = v.gen_waddr; gen_wdata = v.gen_wdata;
    gen_valid = v.gen_valid; rnd_ready = v.rnd_ready; gen_rnd = v.gen_rnd;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_INIT, M_RUN, M_HOLD} mode_e;
  mode_e       m_mode;
  logic [31:0] m_seed, m_cnt;
  bit          m_pending, m_go, m_first;

  task automatic model_reset();
    m_mode = M_IDLE; m_seed = 0; m_cnt = 0; m_pending = 0; m_go = 0; m_first = AUTO;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit took;
    took = gen_valid && rnd_ready && (m_mode == M_RUN);
    if (took && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_go = 0;
    if (m_mode == M_INIT) begin
      if (seed_req) begin m_seed = seed_in; m_pending = 1; end
      if (init_done) begin
        if (m_pending) begin m_go = 1; m_pending = 0; m_cnt = 0; end
        else m_mode = M_RUN;
      end
    end else if (seed_req || m_first) begin
      m_seed = seed_req ? seed_in : 32'd5489;
      m_cnt = 0; m_go = 1; m_pending = 0; m_mode = M_INIT;
    end else if (m_mode == M_RUN && pause) m_mode = M_HOLD;
    else if (m_mode == M_HOLD && resume && !pause) m_mode = M_RUN;
    m_first = 0;
  endtask

  task automatic model_compare(input int cyc);
    logic        e_rv, e_ge, e_rw;
    logic [9:0]  e_ra;
    logic [31:0] e_rd;
    e_rv = gen_valid && (m_mode == M_RUN);
    e_ge = (m_mode == M_RUN) && (rnd_ready || !gen_valid);
    e_rw = 0; e_ra = 0; e_rd = 0;
    if (m_mode == M_INIT) begin e_rw = init_wen; e_ra = init_waddr; e_rd = init_wdata; end
    if (m_mode == M_RUN)  begin e_rw = gen_wen;  e_ra = gen_waddr;  e_rd = gen_wdata;  end
    check($sformatf("rand_ctl@%0d", cyc), {59'd0, busy, init_go, rnd_valid, gen_en, ram_wen},
          {59'd0, m_mode == M_INIT, m_go, e_rv, e_ge, e_rw});
    check($sformatf("rand_seed_cnt@%0d", cyc), {init_seed, word_cnt}, {m_seed, m_cnt});
    check($sformatf("rand_ram@%0d", cyc), {22'd0, ram_waddr, ram_wdata}, {22'd0, e_ra, e_rd});
    check($sformatf("rand_rnd@%0d", cyc), {32'd0, rnd}, {32'd0, gen_rnd});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    reset = 1'b1;
    clear_inputs();

    reset_dut();
    after_reset();

    // Scripted vectors.
    build_table();
    for (int i = 0; i < tv.size(); i++) begin
      apply_vec(tv[i]);
      tick();
      check({tv[i].name, "_ctl"}, {59'd0, busy, init_go, rnd_valid, gen_en, ram_wen},
            {59'd0, tv[i].e_busy, tv[i].e_go, tv[i].e_rv, tv[i].e_ge, tv[i].e_rw});
      check({tv[i].name, "_seed_cnt"}, {init_seed, word_cnt}, {tv[i].e_seed, tv[i].e_cnt});
      check({tv[i].name, "_ram"}, {22'd0, ram_waddr, ram_wdata}, {22'd0, tv[i].e_ra, tv[i].e_rd});
      check({tv[i].name, "_rnd"}, {32'd0, rnd}, {32'd0, tv[i].gen_rnd});
    end
    clear_inputs();

    // Full 624-word init pass with a reseed arriving at word 300.
    for (int i = 0; i < 624; i++) begin
      d = $urandom;
      init_wen = 1; init_waddr = 10'(i); init_wdata = d;
      gen_wen = 1; gen_waddr = ~10'(i); gen_wdata = ~d;
      seed_req = (i == 300);
      seed_in = (i == 300) ? 32'h1234_5678 : 32'h0;
      tick();
      check($sformatf("init_pass_%0d", i), {21'd0, ram_wen, ram_waddr, ram_wdata}, {21'd0, 1'b1, 10'(i), d});
      if (i == 300)
        check("pending_latch", {30'd0, busy, init_go, init_seed}, {30'd0, 1'b1, 1'b0, 32'h1234_5678});
    end
    clear_inputs();
    init_done = 1; tick(); init_done = 0;
    check("pending_restart", {30'd0, busy, init_go, word_cnt}, {30'd0, 1'b1, 1'b1, 32'd0});
    tick();
    check("restart_go_pulse", {62'd0, busy, init_go}, {62'd0, 1'b1, 1'b0});
    init_done = 1; tick(); init_done = 0;
    check("run_after_restart", {62'd0, busy, init_go}, 64'd0);

    // Ten accepted words, then back-pressure stops the engine.
    gen_valid = 1; rnd_ready = 1;
    for (int k = 0; k < 10; k++) begin
      d = $urandom;
      gen_rnd = d;
      tick();
      check($sformatf("rnd_pass_%0d", k), {31'd0, rnd_valid, rnd}, {31'd0, 1'b1, d});
    end
    check("word_cnt_10", {32'd0, word_cnt}, 64'd10);
    rnd_ready = 0;
    #1;
    check("gen_en_backpressure", {63'd0, gen_en}, 64'd0);
    clear_inputs();

    // Reset asserted in the middle of an init pass.
    seed_req = 1; seed_in = 32'd777; tick(); seed_req = 0; seed_in = 0;
    init_wen = 1; init_waddr = 10'd5; init_wdata = 32'hFACE;
    tick(); tick();
    check("mid_init_busy", {63'd0, busy}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_mid_init", all_outs(), 64'd0);
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    after_reset();

    // Randomized run against the model.
    reset_dut();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      seed_req   = ($urandom_range(0, 63) == 0);
      seed_in    = $urandom;
      pause      = ($urandom_range(0, 5) == 0);
      resume     = ($urandom_range(0, 3) == 0);
      init_done  = !seed_req && ($urandom_range(0, 15) == 0);
      init_wen   = $urandom_range(0, 1);
      init_waddr = 10'($urandom);
      init_wdata = $urandom;
      gen_wen    = $urandom_range(0, 1);
      gen_waddr  = 10'($urandom);
      gen_wdata  = $urandom;
      gen_valid  = $urandom_range(0, 1);
      rnd_ready  = $urandom_range(0, 1);
      gen_rnd    = $urandom;
      model_step();
      tick();
      model_compare(c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
